// File: rtl/shift_pkg.sv
// Shared shifter opcodes, widths and the result-queue entry type.
package shift_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct packed {
    logic            op_err;
    logic [XLEN-1:0] result;
  } entry_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// Request (valid/ready) and result (valid/ready) channels of the shift issue stage.
interface shift_issue_stage_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [shift_pkg::XLEN-1:0] in_a;
  logic [shift_pkg::XLEN-1:0] in_b;
  logic [1:0]                 in_op;
  logic                       out_valid;
  logic                       out_ready;
  logic [shift_pkg::XLEN-1:0] out_result;
  logic                       out_op_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op_err
  );

endinterface

// File: rtl/shift_core.sv
// Combinational SLL/SRL/SRA datapath; reserved op passes a through and flags an error.
// SHIFT_AMT_SAT_EN: shift amounts >= 32 saturate instead of using only b[4:0].
module shift_core
  import shift_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [1:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic            op_err_o
);

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    sra_y;
  logic               sat;

  assign shamt = b_i[SHAMT_W-1:0];

`ifdef SHIFT_AMT_SAT_EN
  assign sat = |b_i[XLEN-1:SHAMT_W];
`else
  logic unused_b_hi;
  assign unused_b_hi = ^b_i[XLEN-1:SHAMT_W];
  assign sat         = 1'b0;
`endif

  sra u_sra (
    .a_i    (a_i),
    .shamt_i(shamt),
    .y_o    (sra_y)
  );

  always_comb begin
    result_o = a_i;
    op_err_o = 1'b0;
    unique case (op_i)
      OP_SLL:  result_o = sat ? '0 : (a_i << shamt);
      OP_SRL:  result_o = sat ? '0 : (a_i >> shamt);
      OP_SRA:  result_o = sat ? {XLEN{a_i[XLEN-1]}} : sra_y;
      default: op_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/sra.sv
// 32-bit arithmetic right shift by a 5-bit amount.
module sra
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [XLEN-1:0]    y_o
);

  assign y_o = XLEN'($signed(a_i) >>> shamt_i);

endmodule

// File: rtl/shift_issue_stage.sv
// Issue/retire wrapper: operand register -> shift_core -> 2-entry in-order result queue.
// Honors SHIFT_AMT_SAT_EN through shift_core.
module shift_issue_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_issue_stage_if.slave  bus,
  output logic [CNT_W-1:0]    op_count
);

  logic             op_vld_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [1:0]       op_op_q;
  entry_t           queue_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       q_cnt_q;
  logic [CNT_W-1:0] op_count_q;

  logic [WIDTH-1:0] core_result;
  logic             core_err;
  entry_t           head;
  logic             out_valid;
  logic             out_fire;
  logic             advance;
  logic             in_ready;
  logic             accept;

  shift_core u_core (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .op_i    (op_op_q),
    .result_o(core_result),
    .op_err_o(core_err)
  );

  always_comb begin
    head      = queue_q[rd_ptr_q];
    out_valid = (q_cnt_q != 2'd0);
    out_fire  = out_valid && bus.out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    advance   = op_vld_q && ((q_cnt_q < 2'd2) || out_fire);
    in_ready  = !op_vld_q || advance;
    accept    = bus.in_valid && in_ready;
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_valid ? head.result : '0;
  assign bus.out_op_err = out_valid ? head.op_err : 1'b0;
  assign op_count       = op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_op_q    <= OP_SLL;
      queue_q[0] <= '0;
      queue_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      q_cnt_q    <= 2'd0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        op_vld_q <= 1'b1;
        op_a_q   <= bus.in_a;
        op_b_q   <= bus.in_b;
        op_op_q  <= bus.in_op;
      end else if (advance) begin
        op_vld_q <= 1'b0;
      end
      if (advance) begin
        queue_q[wr_ptr_q] <= '{op_err: core_err, result: core_result};
        wr_ptr_q          <= ~wr_ptr_q;
        op_count_q        <= op_count_q + 1'b1;
      end
      if (out_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({advance, out_fire})
        2'b10:   q_cnt_q <= q_cnt_q + 2'd1;
        2'b01:   q_cnt_q <= q_cnt_q - 2'd1;
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed cases plus randomized traffic
// scored against an in-order queue of reference results.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic [15:0] op_count;

  shift_issue_stage_if bus ();

  shift_issue_stage #(
    .WIDTH(32),
    .CNT_W(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          accepts = 0;
  logic [32:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: {op_err, result} from the architectural shift rules.
  function automatic logic [32:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    int unsigned sh;
    logic        sat;
    logic [31:0] r;
    sh  = b % 32;
    sat = 1'b0;
`ifdef SHIFT_AMT_SAT_EN
    sat = (b >= 32);
`endif
    case (op)
      2'd0:    r = sat ? 32'h0 : a << sh;
      2'd1:    r = sat ? 32'h0 : a >> sh;
      2'd2:    r = sat ? (a[31] ? 32'hFFFF_FFFF : 32'h0) : 32'($signed(a) >>> sh);
      default: return {1'b1, a};
    endcase
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check("out_result", bus.out_result, exp_q[0][31:0]);
          check("out_op_err", 32'(bus.out_op_err), 32'(exp_q[0][32]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_result", bus.out_result, 32'h0);
        check("idle_op_err", 32'(bus.out_op_err), 32'h0);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_shift(bus.in_a, bus.in_b, bus.in_op));
        accepts++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic acc;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    n            = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [31:0] exp, input logic err);
    int n;
    bus.out_ready = 1'b0;
    send(a, b, op);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 10);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.out_result, exp);
    check({tag, "_err"}, 32'(bus.out_op_err), 32'(err));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("op_count", 32'(op_count), 32'(accepts[15:0]));
  endtask

  initial begin : main
    int          idx;
    logic [31:0] ra [4];
    logic        acc;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 2'd0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'h0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-cycle latency for the first request.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'h8000_0000;
    bus.in_b      = 32'd1;
    bus.in_op     = 2'd2;
    @(negedge clk);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("t1_valid_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_result", bus.out_result, 32'hC000_0000);
    check("t1_op_count", 32'(op_count), 32'd1);
    drain();

    expect_one("sra5", 32'h08DF_0000, 32'd5, 2'd2, 32'h0046_F800, 1'b0);
    expect_one("srl31", 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001, 1'b0);
    expect_one("sra31", 32'h8000_0000, 32'd31, 2'd2, 32'hFFFF_FFFF, 1'b0);
`ifdef SHIFT_AMT_SAT_EN
    expect_one("sra32", 32'h8000_0000, 32'h20, 2'd2, 32'hFFFF_FFFF, 1'b0);
    expect_one("sll32", 32'h8000_0000, 32'h20, 2'd0, 32'h0000_0000, 1'b0);
`else
    expect_one("sra32", 32'h8000_0000, 32'h20, 2'd2, 32'h8000_0000, 1'b0);
    expect_one("sll32", 32'h8000_0000, 32'h20, 2'd0, 32'h8000_0000, 1'b0);
`endif
    expect_one("rsv", 32'h1234_5678, 32'd3, 2'd3, 32'h1234_5678, 1'b1);
    drain();

    // Back-pressure: four consecutive requests with the consumer stalled.
    ra[0] = 32'h0000_0001; ra[1] = 32'h0000_0002; ra[2] = 32'h0000_0004; ra[3] = 32'h0000_0008;
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = ra[idx];
      bus.in_b     = 32'd4;
      bus.in_op    = 2'd0;
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("bp_accepts", 32'(idx), 32'd3);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    bus.in_a      = ra[3];
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end while (!acc);
    bus.in_valid = 1'b0;
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_a     = $urandom;
        bus.in_b     = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
        bus.in_op    = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with the queue full and the operand register occupied.
    bus.out_ready = 1'b0;
    send(32'h1, 32'd1, 2'd0);
    send(32'h2, 32'd1, 2'd0);
    send(32'h3, 32'd1, 2'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_result", bus.out_result, 32'h0);
    exp_q.delete();
    accepts = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_one("post_rst", 32'hF000_000F, 32'd4, 2'd1, 32'h0F00_0000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
